// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry defaults, architectural
// register indices and the write-destination select codes used upstream of
// the write-back register file.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Destination-register select, resolved in decode before the index
    // travels down the pipe to write-back.
    typedef enum logic [1:0] {
        DST_RT = 2'b00,
        DST_RA = 2'b01,
        DST_RD = 2'b10
    } dst_sel_e;

    // Resolve a destination select into a register index. An unused select
    // code points at $0 so a stray encoding can never corrupt state.
    function automatic logic [4:0] dst_addr(input dst_sel_e   sel,
                                            input logic [4:0] rt,
                                            input logic [4:0] rd);
        logic [4:0] a;
        case (sel)
            DST_RT:  a = rt;
            DST_RA:  a = REG_RA;
            DST_RD:  a = rd;
            default: a = REG_ZERO;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: hardwired-zero check, then
// same-cycle write-back bypass, then the stored value.
module rf_read_port
    import cpu_pkg::*;
#(
    parameter int                 DATA_W   = DATA_W_DEF,
    parameter int                 ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0]  ZERO_IDX = ADDR_W'(REG_ZERO),
    localparam int                DEPTH    = 2 ** ADDR_W
) (
    input  logic                          rst_n,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             waddr,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
    input  logic [ADDR_W-1:0]             raddr,
    output logic [DATA_W-1:0]             rdata
);

    // Priority mux: $0, reset, bypass from the write port, then storage.
    always_comb begin
        // NOTE: rdata gets a default before any branch so every path assigns
        // it and no latch is inferred.
        rdata = mem[raddr];
        if (raddr == ZERO_IDX) begin
            rdata = '0;
        end else if (!rst_n) begin
            // Storage is already clear in reset; the bypass must not leak
            // wdata around it.
            rdata = '0;
        end else if (we && (waddr == raddr)) begin
            rdata = wdata;
        end
    end

endmodule

// File: rtl/wb_reg_file.sv
// Write-back register file: 2**ADDR_W x DATA_W registers, two combinational
// read ports with write-to-read bypass, one synchronous write port, and a
// committed-write counter. Index ZERO_IDX reads zero and ignores writes.
// Optional build macro REGFILE_DBG_PORT_EN adds a third raw read port
// (dbg_addr/dbg_data) without bypass, used for register dumps.
module wb_reg_file
    import cpu_pkg::*;
#(
    parameter int                 DATA_W   = DATA_W_DEF,
    parameter int                 ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0]  ZERO_IDX = ADDR_W'(REG_ZERO),
    localparam int                DEPTH    = 2 ** ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [ADDR_W-1:0]  raddr1,
    output logic [DATA_W-1:0]  rdata1,
    input  logic [ADDR_W-1:0]  raddr2,
    output logic [DATA_W-1:0]  rdata2,
    output logic [15:0]        wr_cnt
`ifdef REGFILE_DBG_PORT_EN
    ,
    input  logic [ADDR_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
`endif
);

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic                         wr_commit;

    // A write commits only to a real register; $0 writes are dropped and
    // do not count.
    assign wr_commit = we && (waddr != ZERO_IDX);

    // Register storage and write counter; reset clears both immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the whole array is reset on purpose so reads of never
            // written registers return 0, not X; this keeps it in flops
            // rather than a RAM macro.
            mem    <= '0;
            wr_cnt <= '0;
        end else if (wr_commit) begin
            // NOTE: state updates use <= so every register samples its
            // inputs from before the edge.
            mem[waddr] <= wdata;
            wr_cnt     <= wr_cnt + 16'd1;
        end
    end

    rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_IDX (ZERO_IDX)
    ) u_rd1 (
        .rst_n (rst_n),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .mem   (mem),
        .raddr (raddr1),
        .rdata (rdata1)
    );

    rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_IDX (ZERO_IDX)
    ) u_rd2 (
        .rst_n (rst_n),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .mem   (mem),
        .raddr (raddr2),
        .rdata (rdata2)
    );

`ifdef REGFILE_DBG_PORT_EN
    // Raw storage view for register dumps: no bypass, $0 reads 0.
    assign dbg_data = (dbg_addr == ZERO_IDX) ? '0 : mem[dbg_addr];
`else
    // Debug read port not built.
`endif

endmodule

// File: tb/tb_wb_reg_file.sv
// Self-checking bench for wb_reg_file: a reference model of the register
// file and counter produces expected values that are queued when stimulus is
// applied and compared when the outputs are sampled.
module tb_wb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [15:0] wr_cnt;
`ifdef REGFILE_DBG_PORT_EN
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
`endif

    wb_reg_file dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .wr_cnt   (wr_cnt)
`ifdef REGFILE_DBG_PORT_EN
        ,
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {SRC_R1, SRC_R2, SRC_CNT} src_e;
    typedef struct {
        src_e        src;
        string       tag;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    logic [31:0] model [32];
    logic [15:0] model_cnt;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
        model_cnt = '0;
    endtask

    // Expected read value from the currently driven inputs and the model.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0)               return '0;
        if (!rst_n)                  return '0;
        if (we && (waddr == a))      return wdata;
        return model[a];
    endfunction

    task automatic push(input src_e src, input string tag, input logic [31:0] exp);
        sb_entry_t e;
        e.src = src;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic expect_rd1(input string tag);
        push(SRC_R1, tag, exp_read(raddr1));
    endtask

    task automatic expect_rd2(input string tag);
        push(SRC_R2, tag, exp_read(raddr2));
    endtask

    task automatic expect_cnt(input string tag);
        push(SRC_CNT, tag, {16'h0, model_cnt});
    endtask

    // Pop every pending expectation and compare it with the live output.
    task automatic drain();
        sb_entry_t   e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.src)
                SRC_R1:  obs = rdata1;
                SRC_R2:  obs = rdata2;
                default: obs = {16'h0, wr_cnt};
            endcase
            check(e.tag, obs, e.exp);
        end
    endtask

    // Advance through a rising edge and mirror what it commits.
    task automatic commit_edge();
        @(posedge clk);
        if (rst_n && we && (waddr != 5'd0)) begin
            model[waddr] = wdata;
            model_cnt    = model_cnt + 16'd1;
        end
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        commit_edge();
    endtask

    task automatic idle();
        @(negedge clk);
        we = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b1;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr1 = 5'd5;
        raddr2 = 5'd31;
`ifdef REGFILE_DBG_PORT_EN
        dbg_addr = '0;
`endif
        model_clear();

        // Reset, with a write attempt that must be ignored and not bypassed.
        #1 rst_n = 1'b0;
        model_clear();
        we    = 1'b1;
        waddr = 5'd5;
        wdata = 32'h0000_1234;
        repeat (2) @(posedge clk);
        #1;
        expect_rd1("rst_rd1");
        expect_rd2("rst_rd2");
        expect_cnt("rst_cnt");
        drain();
        @(negedge clk);
        we    = 1'b0;
        rst_n = 1'b1;
        #1;
        expect_rd1("rel_rd1_5");
        expect_cnt("rel_cnt");
        drain();

        // Basic write then read back from storage.
        do_write(5'd8, 32'hDEAD_BEEF);
        idle();
        raddr1 = 5'd8;
        #1;
        expect_rd1("wr8_rd1");
        expect_cnt("wr8_cnt");
        drain();

        // Write to $0: reads zero, counter unchanged, zero beats bypass.
        @(negedge clk);
        we     = 1'b1;
        waddr  = 5'd0;
        wdata  = 32'hFFFF_FFFF;
        raddr1 = 5'd0;
        #1;
        expect_rd1("zero_pre");
        drain();
        commit_edge();
        idle();
        #1;
        expect_rd1("zero_post");
        expect_cnt("zero_cnt");
        drain();

        // Fill all registers with random data, then read pairs back.
        for (int i = 1; i < 32; i++) do_write(5'(i), $urandom);
        idle();
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            expect_rd1("fill_rd1");
            expect_rd2("fill_rd2");
            drain();
        end
        expect_cnt("fill_cnt");
        drain();

        // Dual-port bypass on $31, continuous across the edge.
        do_write(5'd31, 32'h0000_0001);
        idle();
        @(negedge clk);
        we     = 1'b1;
        waddr  = 5'd31;
        wdata  = 32'h0040_0008;
        raddr1 = 5'd31;
        raddr2 = 5'd31;
        #1;
        expect_rd1("byp_pre_rd1");
        expect_rd2("byp_pre_rd2");
        drain();
        commit_edge();
        we = 1'b0;
        #1;
        expect_rd1("byp_post_rd1");
        expect_rd2("byp_post_rd2");
        drain();

        // Bypass on one port only; the other reads storage.
        @(negedge clk);
        we     = 1'b1;
        waddr  = 5'd12;
        wdata  = 32'hA5A5_5A5A;
        raddr1 = 5'd12;
        raddr2 = 5'd8;
        #1;
        expect_rd1("byp1_rd1");
        expect_rd2("byp1_rd2");
        drain();
        commit_edge();
        idle();

        // Reset asserted mid-cycle with a pending write to $9.
        do_write(5'd9, 32'h0000_0007);
        @(negedge clk);
        we     = 1'b1;
        waddr  = 5'd9;
        wdata  = 32'h0000_0005;
        raddr1 = 5'd9;
        raddr2 = 5'd8;
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        expect_rd1("rstmid_rd1");
        expect_rd2("rstmid_rd2");
        drain();
        @(posedge clk);
        #1;
        @(negedge clk);
        we    = 1'b0;
        rst_n = 1'b1;
        #1;
        expect_rd1("rstrel_rd1_9");
        expect_rd2("rstrel_rd2_8");
        expect_cnt("rstrel_cnt");
        drain();

        // Counter wrap: 65536 committed writes to $3.
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            we    = 1'b1;
            waddr = 5'd3;
            wdata = 32'(i);
            if (i == 65535) begin
                #1;
                expect_cnt("wrap_ffff");
                drain();
            end
            commit_edge();
        end
        idle();
        raddr1 = 5'd3;
        #1;
        expect_rd1("wrap_rd3");
        expect_cnt("wrap_cnt");
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
